// File: rtl/irq_ctrl.sv
// irq_ctrl: parametrised 68k interrupt controller.
// Synchronises active-low request lines, applies per-channel mask and
// edge/level mode, drives the encoded active-low IPL bus and answers IACK
// cycles with a vector number, an autovector request or a spurious flag.
// Build option: define IRQ_AUTOVECTOR_EN to answer every hit with avec_n
// instead of vector/vector_valid.
module irq_ctrl #(
    parameter int                  NUM_CH      = 4,
    // Packed 3-bit level per channel, channel i in bits [3i+2:3i].
    // Default: channel 0 = level 2, 1 = level 3, 2 = level 4, 3 = level 5.
    parameter logic [3*NUM_CH-1:0] CH_LEVELS   = {3'd5, 3'd4, 3'd3, 3'd2},
    parameter logic [NUM_CH-1:0]   EDGE_MASK   = '0,
    parameter logic [7:0]          VECTOR_BASE = 8'h40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] irq_n,
    input  logic [NUM_CH-1:0] irq_mask,
    input  logic              iack,
    input  logic [2:0]        iack_level,
    output logic [2:0]        ipl_n,
    output logic [7:0]        vector,
    output logic              vector_valid,
    output logic              avec_n,
    output logic              spurious
);

    localparam logic [7:0] SPURIOUS_VECTOR = 8'h18;

    // The synchroniser flops hold the inverted (active-high) request, so
    // their reset value of 0 means "no request" and no false edge appears
    // when reset is released with all lines idle.
    logic [NUM_CH-1:0] sync1_reg;
    logic [NUM_CH-1:0] sync2_reg;
    logic [NUM_CH-1:0] req_d_reg;
    logic [NUM_CH-1:0] pending_reg;
    logic [NUM_CH-1:0] pending_next;

    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] active;
    logic [NUM_CH-1:0] eligible;
    logic [2:0]        ch_level [NUM_CH];

    logic [2:0]        win_level;
    logic              hit;
    logic [2:0]        hit_idx;
    logic              ack_clear;

    logic [2:0]        ipl_n_next;
    logic [7:0]        vector_next;
    logic              vector_valid_next;
    logic              avec_n_next;
    logic              spurious_next;

    assign ack_clear = iack & hit;

    // Two-flop synchroniser plus one-cycle delayed copy for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            req_d_reg <= '0;
        end else begin
            sync1_reg <= ~irq_n;
            sync2_reg <= sync1_reg;
            req_d_reg <= sync2_reg;
        end
    end

    // Per-channel mode, activity and eligibility.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [2:0] LVL = CH_LEVELS[3*gi +: 3];

            assign ch_level[gi] = LVL;
            assign rise[gi]     = sync2_reg[gi] & ~req_d_reg[gi];

            if (EDGE_MASK[gi]) begin : g_edge
                // The edge counts in the cycle it is seen, so edge channels
                // reach ipl_n with the same latency as level channels.
                assign active[gi]       = pending_reg[gi] | rise[gi];
                // A new edge in the acknowledge cycle wins over the clear.
                assign pending_next[gi] = rise[gi] |
                    (pending_reg[gi] & ~(ack_clear && (hit_idx == 3'(gi))));
            end else begin : g_level
                assign active[gi]       = sync2_reg[gi];
                assign pending_next[gi] = 1'b0;
            end

            // Mask only gates eligibility; latching above ignores it.
            assign eligible[gi] = active[gi] & ~irq_mask[gi] & (LVL != 3'd0);
        end
    endgenerate

    // Pending edge latches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    // Highest level among eligible channels drives the IPL bus.
    always_comb begin
        win_level = 3'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (eligible[i] && (ch_level[i] > win_level)) begin
                win_level = ch_level[i];
            end
        end
        ipl_n_next = ~win_level;
    end

    // IACK match: lowest-index eligible channel at the acknowledged level.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 3'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (eligible[i] && (ch_level[i] == iack_level)) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
    end

    // Response for the current IACK; strobes are idle otherwise.
    always_comb begin
        vector_next       = 8'h00;
        vector_valid_next = 1'b0;
        avec_n_next       = 1'b1;
        spurious_next     = 1'b0;
        if (iack) begin
            if (hit) begin
`ifdef IRQ_AUTOVECTOR_EN
                avec_n_next       = 1'b0;
`else
                vector_next       = VECTOR_BASE + {5'd0, hit_idx};
                vector_valid_next = 1'b1;
`endif
            end else begin
                vector_next   = SPURIOUS_VECTOR;
                spurious_next = 1'b1;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ipl_n        <= 3'b111;
            vector       <= 8'h00;
            vector_valid <= 1'b0;
            avec_n       <= 1'b1;
            spurious     <= 1'b0;
        end else begin
            ipl_n        <= ipl_n_next;
            vector       <= vector_next;
            vector_valid <= vector_valid_next;
            avec_n       <= avec_n_next;
            spurious     <= spurious_next;
        end
    end

endmodule
